// File: rtl/wb_tgt_chk_pkg.sv
// Shared definitions for the pipelined Wishbone target-port protocol checker:
// violation bit indices, checker state encoding and a priority helper.
package wb_tgt_chk_pkg;

  localparam int VIOL_WIDTH          = 7;
  localparam int VIOL_MULTI_TERM     = 0;
  localparam int VIOL_UNEXP_TERM     = 1;
  localparam int VIOL_CYC_DROP       = 2;
  localparam int VIOL_OVERFLOW       = 3;
  localparam int VIOL_STALL_UNSTABLE = 4;
  localparam int VIOL_TIMEOUT        = 5;
  localparam int VIOL_STB_NO_CYC     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    PENDING = 2'd2
  } state_e;

  // Lowest set index wins, so bit 0 is the highest-priority violation.
  function automatic logic [2:0] lowest_viol(input logic [VIOL_WIDTH-1:0] v);
    lowest_viol = 3'd0;
    for (int i = VIOL_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_viol = 3'(i);
    end
  endfunction

endpackage

// File: rtl/wb_tgt_chk_log.sv
// Sticky violation log: per-bit flags, saturating count of violating cycles
// and first-violation capture. A violation coincident with clear survives it.
module wb_tgt_chk_log
  import wb_tgt_chk_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic [VIOL_WIDTH-1:0] i_viol,
  output logic [VIOL_WIDTH-1:0] o_viol,
  output logic [CNT_WIDTH-1:0]  o_cnt,
  output logic [2:0]            o_first,
  output logic                  o_first_vld
);

  logic                  w_any;
  logic [VIOL_WIDTH-1:0] r_viol;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [2:0]            r_first;
  logic                  r_first_vld;

  assign w_any = |i_viol;

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_viol      <= '0;
      r_cnt       <= '0;
      r_first     <= '0;
      r_first_vld <= 1'b0;
    end else if (i_clr) begin
      r_viol      <= i_viol;
      r_cnt       <= CNT_WIDTH'(w_any);
      r_first     <= lowest_viol(i_viol);
      r_first_vld <= w_any;
    end else begin
      r_viol <= r_viol | i_viol;
      if (w_any && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (w_any && !r_first_vld) begin
        r_first     <= lowest_viol(i_viol);
        r_first_vld <= 1'b1;
      end
    end
  end

  assign o_viol      = r_viol;
  assign o_cnt       = r_cnt;
  assign o_first     = r_first;
  assign o_first_vld = r_first_vld;

endmodule

// File: rtl/wb_tgt_chk.sv
// Passive run-time protocol checker for a pipelined Wishbone target port.
// Define WBXBC_TGT_CHK_STABLE_EN to check request stability during stall.
module wb_tgt_chk
  import wb_tgt_chk_pkg::*;
#(
  parameter int ADR_WIDTH       = 16,
  parameter int DAT_WIDTH       = 16,
  parameter int SEL_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 256,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                                   clk_i,
  input  logic                                   async_rst_n_i,
  input  logic                                   clr_i,
  input  logic                                   tgt_cyc_o,
  input  logic                                   tgt_stb_o,
  input  logic                                   tgt_we_o,
  input  logic [SEL_WIDTH-1:0]                   tgt_sel_o,
  input  logic [ADR_WIDTH-1:0]                   tgt_adr_o,
  input  logic [DAT_WIDTH-1:0]                   tgt_dat_o,
  input  logic                                   tgt_ack_i,
  input  logic                                   tgt_err_i,
  input  logic                                   tgt_rty_i,
  input  logic                                   tgt_stall_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   busy_o,
  output logic [VIOL_WIDTH-1:0]                  viol_o,
  output logic                                   viol_irq_o,
  output logic [CNT_WIDTH-1:0]                   viol_cnt_o,
  output logic [2:0]                             first_viol_o,
  output logic                                   first_vld_o
);

  localparam int                OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [OUT_W:0]    OUT_MAX = (OUT_W + 1)'(MAX_OUTSTANDING);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_HOLD = TO_W'(TIMEOUT);

  state_e                r_state;
  logic [OUT_W-1:0]      r_outstanding;
  logic [TO_W-1:0]       r_to_cnt;

  logic                  w_req;
  logic                  w_term;
  logic                  w_dec;
  logic                  w_unstable;
  logic [OUT_W:0]        w_sum;
  logic [OUT_W-1:0]      w_out_next;
  logic [VIOL_WIDTH-1:0] w_viol;

  assign w_req  = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
  assign w_term = tgt_ack_i | tgt_err_i | tgt_rty_i;
  assign w_dec  = w_term & (r_outstanding != '0);

  // NOTE: every always_comb output is assigned first, so no latch can form.
  always_comb begin
    w_sum = {1'b0, r_outstanding} + (OUT_W + 1)'(w_req) - (OUT_W + 1)'(w_dec);
    if (!tgt_cyc_o)         w_out_next = '0;
    else if (w_sum > OUT_MAX) w_out_next = OUT_MAX[OUT_W-1:0];
    else                    w_out_next = w_sum[OUT_W-1:0];
  end

`ifdef WBXBC_TGT_CHK_STABLE_EN
  logic                 r_stb_stall;
  logic                 r_we;
  logic [SEL_WIDTH-1:0] r_sel;
  logic [ADR_WIDTH-1:0] r_adr;
  logic [DAT_WIDTH-1:0] r_dat;

  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      r_stb_stall <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
    end else begin
      r_stb_stall <= tgt_stb_o & tgt_stall_i;
      r_we        <= tgt_we_o;
      r_sel       <= tgt_sel_o;
      r_adr       <= tgt_adr_o;
      r_dat       <= tgt_dat_o;
    end
  end

  // Write data only matters for the held request when it is a write.
  assign w_unstable = r_stb_stall & tgt_stb_o &
                      ((tgt_adr_o != r_adr) || (tgt_sel_o != r_sel) ||
                       (tgt_we_o != r_we) || (tgt_we_o && (tgt_dat_o != r_dat)));
`else
  logic w_unused;
  assign w_unstable = 1'b0;
  assign w_unused   = ^{tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o};
`endif

  always_comb begin
    w_viol                      = '0;
    w_viol[VIOL_MULTI_TERM]     = (tgt_ack_i & tgt_err_i) | (tgt_ack_i & tgt_rty_i) |
                                  (tgt_err_i & tgt_rty_i);
    w_viol[VIOL_UNEXP_TERM]     = w_term & (r_outstanding == '0);
    w_viol[VIOL_CYC_DROP]       = ~tgt_cyc_o & (r_outstanding != '0);
    w_viol[VIOL_OVERFLOW]       = w_req & ~w_term & ({1'b0, r_outstanding} == OUT_MAX);
    w_viol[VIOL_STALL_UNSTABLE] = w_unstable;
    w_viol[VIOL_TIMEOUT]        = (r_state == PENDING) && (r_to_cnt == TO_LAST);
    w_viol[VIOL_STB_NO_CYC]     = tgt_stb_o & ~tgt_cyc_o;
  end

  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      r_state       <= IDLE;
      r_outstanding <= '0;
      r_to_cnt      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      // Parking at TIMEOUT (one past the firing value) gives one flag per stall.
      if (!tgt_cyc_o || w_term || (r_outstanding == '0)) r_to_cnt <= '0;
      else if ((r_state == PENDING) && (r_to_cnt != TO_HOLD)) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (!tgt_cyc_o) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE:    r_state <= ACTIVE;
          ACTIVE:  if (w_out_next != '0) r_state <= PENDING;
          PENDING: if (w_out_next == '0) r_state <= ACTIVE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  wb_tgt_chk_log #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_log (
    .i_clk       (clk_i),
    .i_rst_n     (async_rst_n_i),
    .i_clr       (clr_i),
    .i_viol      (w_viol),
    .o_viol      (viol_o),
    .o_cnt       (viol_cnt_o),
    .o_first     (first_viol_o),
    .o_first_vld (first_vld_o)
  );

  assign outstanding_o = r_outstanding;
  assign busy_o        = (r_state != IDLE);
  assign viol_irq_o    = |viol_o;

endmodule

// File: tb/tb_wb_tgt_chk.sv
// Self-checking bench for wb_tgt_chk: directed protocol scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_wb_tgt_chk;

  localparam int MAXO = 4;
  localparam int TMO  = 8;
  localparam int CNTW = 8;
  localparam int CMAX = (1 << CNTW) - 1;
`ifdef WBXBC_TGT_CHK_STABLE_EN
  localparam bit STABLE = 1'b1;
`else
  localparam bit STABLE = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        async_rst_n_i;
  logic        clr_i;
  logic        cyc, stb, we, ack, err, rty, stall;
  logic [1:0]  sel;
  logic [15:0] adr, dat;
  logic [2:0]  outstanding_o;
  logic        busy_o, viol_irq_o, first_vld_o;
  logic [6:0]  viol_o;
  logic [7:0]  viol_cnt_o;
  logic [2:0]  first_viol_o;

  int n_tests, n_fail;

  // Behavioural model: a queue of accepted requests plus the spec's log rules.
  int          m_q[$];
  int          m_seq, m_state, m_to;
  bit          m_pss, m_pwe;
  logic [15:0] m_padr, m_pdat;
  logic [1:0]  m_psel;
  bit   [6:0]  m_viol;
  int          m_cnt, m_first;
  bit          m_fvld;

  wb_tgt_chk #(
    .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_i(clk_i), .async_rst_n_i(async_rst_n_i), .clr_i(clr_i),
    .tgt_cyc_o(cyc), .tgt_stb_o(stb), .tgt_we_o(we), .tgt_sel_o(sel),
    .tgt_adr_o(adr), .tgt_dat_o(dat),
    .tgt_ack_i(ack), .tgt_err_i(err), .tgt_rty_i(rty), .tgt_stall_i(stall),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .viol_o(viol_o),
    .viol_irq_o(viol_irq_o), .viol_cnt_o(viol_cnt_o),
    .first_viol_o(first_viol_o), .first_vld_o(first_vld_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic m_reset();
    m_q.delete();
    m_state = 0; m_to = 0; m_pss = 0; m_pwe = 0; m_padr = '0; m_pdat = '0; m_psel = '0;
    m_viol = '0; m_cnt = 0; m_first = 0; m_fvld = 0;
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; ack = 0; err = 0; rty = 0; stall = 0; clr_i = 0;
    sel = '0; adr = '0; dat = '0;
  endtask

  // Advance one clock with the currently driven inputs and update the model.
  task automatic step();
    bit [6:0] v;
    int n, nt, lo;
    bit req, term;
    n    = m_q.size();
    req  = cyc && stb && !stall;
    term = ack || err || rty;
    nt   = int'(ack) + int'(err) + int'(rty);
    v    = '0;
    v[0] = (nt > 1);
    v[1] = term && (n == 0);
    v[2] = !cyc && (n > 0);
    v[3] = req && (n == MAXO) && !term;
    v[4] = STABLE && m_pss && stb &&
           ((adr != m_padr) || (sel != m_psel) || (we != m_pwe) || (we && dat != m_pdat));
    v[5] = (m_state == 2) && (m_to == TMO - 1);
    v[6] = stb && !cyc;
    lo = 0;
    for (int i = 6; i >= 0; i--) if (v[i]) lo = i;
    @(posedge clk_i); #1;
    if (!cyc) m_q.delete();
    else begin
      if (term && m_q.size() > 0) void'(m_q.pop_front());
      if (req && m_q.size() < MAXO) begin m_q.push_back(m_seq); m_seq++; end
    end
    if (!cyc || term || n == 0) m_to = 0;
    else if (m_state == 2 && m_to < TMO) m_to++;
    if (!cyc) m_state = 0;
    else if (m_state == 0) m_state = 1;
    else if (m_state == 1 && m_q.size() > 0) m_state = 2;
    else if (m_state == 2 && m_q.size() == 0) m_state = 1;
    m_pss = stb && stall; m_padr = adr; m_psel = sel; m_pwe = we; m_pdat = dat;
    if (clr_i) begin
      m_viol = v; m_cnt = (v != 0); m_fvld = (v != 0); m_first = lo;
    end else begin
      m_viol |= v;
      if (v != 0 && m_cnt < CMAX) m_cnt++;
      if (v != 0 && !m_fvld) begin m_fvld = 1; m_first = lo; end
    end
  endtask

  // One cycle with cyc high, nothing requested, log cleared.
  task automatic start_clean();
    bus_idle(); cyc = 1; clr_i = 1; step(); clr_i = 0;
  endtask

  task automatic end_cyc();
    bus_idle(); step();
  endtask

  task automatic test_reset();
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding got %0d exp 0", outstanding_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    n_tests++; if (viol_o !== 7'd0) begin n_fail++; $display("FAIL rst_viol got %b exp 0", viol_o); end
    n_tests++; if (viol_irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b exp 0", viol_irq_o); end
    n_tests++; if (viol_cnt_o !== 8'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", viol_cnt_o); end
    n_tests++; if ({first_viol_o, first_vld_o} !== 4'd0) begin n_fail++; $display("FAIL rst_first got %0d/%b exp 0/0", first_viol_o, first_vld_o); end
    end_cyc();
    n_tests++; if (viol_o !== 7'd0) begin n_fail++; $display("FAIL idle_viol got %b exp 0", viol_o); end
  endtask

  task automatic test_back_to_back();
    int exp_out[6] = '{1, 2, 3, 2, 1, 0};
    start_clean();
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy_o); end
    for (int i = 0; i < 6; i++) begin
      cyc = 1; stb = (i < 3); ack = (i >= 3); adr = 16'(i * 4); dat = 16'(i);
      step();
      n_tests++; if (outstanding_o !== 3'(exp_out[i])) begin n_fail++; $display("FAIL b2b_out[%0d] got %0d exp %0d", i, outstanding_o, exp_out[i]); end
      n_tests++; if (viol_o !== 7'd0) begin n_fail++; $display("FAIL b2b_viol[%0d] got %b exp 0", i, viol_o); end
    end
    end_cyc();
  endtask

  task automatic test_overflow();
    int exp_out[5] = '{1, 2, 3, 4, 4};
    start_clean();
    for (int i = 0; i < 5; i++) begin
      cyc = 1; stb = 1; adr = 16'(16 * i);
      step();
      n_tests++; if (outstanding_o !== 3'(exp_out[i])) begin n_fail++; $display("FAIL ovf_out[%0d] got %0d exp %0d", i, outstanding_o, exp_out[i]); end
    end
    n_tests++; if (viol_o !== 7'b0001000) begin n_fail++; $display("FAIL ovf_viol got %b exp 0001000", viol_o); end
    n_tests++; if (viol_cnt_o !== 8'd1) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 1", viol_cnt_o); end
    n_tests++; if ({first_viol_o, first_vld_o} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL ovf_first got %0d/%b exp 3/1", first_viol_o, first_vld_o); end
    n_tests++; if (viol_irq_o !== 1'b1) begin n_fail++; $display("FAIL ovf_irq got %b exp 1", viol_irq_o); end
    stb = 0; ack = 1;
    repeat (4) step();
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL ovf_drain got %0d exp 0", outstanding_o); end
    end_cyc();
  endtask

  task automatic test_multi_term();
    start_clean();
    stb = 1; step();
    stb = 0; ack = 1; err = 1; step();
    n_tests++; if (viol_o !== 7'b0000001) begin n_fail++; $display("FAIL mt_viol got %b exp 0000001", viol_o); end
    n_tests++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL mt_out got %0d exp 0", outstanding_o); end
    n_tests++; if (first_viol_o !== 3'd0 || first_vld_o !== 1'b1) begin n_fail++; $display("FAIL mt_first got %0d/%b exp 0/1", first_viol_o, first_vld_o); end
    end_cyc();
  endtask

  task automatic test_timeout();
    start_clean();
    stb = 1; step();
    stb = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++; if (viol_o[5] !== (k == 8)) begin n_fail++; $display("FAIL to_edge[%0d] got %b exp %b", k, viol_o[5], (k == 8)); end
    end
    repeat (5) step();
    n_tests++; if (viol_cnt_o !== 8'd1 || viol_o !== 7'b0100000) begin n_fail++; $display("FAIL to_once got cnt %0d viol %b exp 1 0100000", viol_cnt_o, viol_o); end
    ack = 1; step(); ack = 0;
    n_tests++; if (viol_cnt_o !== 8'd1 || outstanding_o !== 3'd0) begin n_fail++; $display("FAIL to_late_ack got cnt %0d out %0d exp 1 0", viol_cnt_o, outstanding_o); end
    end_cyc();
  endtask

  task automatic test_stall_unstable();
    start_clean();
    stb = 1; stall = 1; adr = 16'h0010; step();
    adr = 16'h0014; step();
    n_tests++; if (viol_o[4] !== STABLE) begin n_fail++; $display("FAIL stab_flag got %b exp %b", viol_o[4], STABLE); end
    stall = 0; step();
    stb = 0; ack = 1; step();
    n_tests++; if (outstanding_o !== 3'd0 || viol_cnt_o !== 8'(STABLE)) begin n_fail++; $display("FAIL stab_after got out %0d cnt %0d exp 0 %0d", outstanding_o, viol_cnt_o, STABLE); end
    end_cyc();
  endtask

  task automatic test_clr_unexp();
    bus_idle(); stb = 1; step();
    n_tests++; if (viol_o[6] !== 1'b1) begin n_fail++; $display("FAIL stbnc_flag got %b exp 1", viol_o[6]); end
    bus_idle(); cyc = 1; ack = 1; clr_i = 1; step();
    n_tests++; if (viol_o !== 7'b0000010) begin n_fail++; $display("FAIL clr_viol got %b exp 0000010", viol_o); end
    n_tests++; if (viol_cnt_o !== 8'd1) begin n_fail++; $display("FAIL clr_cnt got %0d exp 1", viol_cnt_o); end
    n_tests++; if (first_viol_o !== 3'd1 || first_vld_o !== 1'b1) begin n_fail++; $display("FAIL clr_first got %0d/%b exp 1/1", first_viol_o, first_vld_o); end
    end_cyc();
  endtask

  task automatic test_reset_mid();
    start_clean();
    stb = 1; repeat (5) step();
    stb = 0; repeat (3) step();
    n_tests++; if (busy_o !== 1'b1 || viol_o === 7'd0) begin n_fail++; $display("FAIL rmid_pre got busy %b viol %b exp 1 nonzero", busy_o, viol_o); end
    #2 async_rst_n_i = 0;
    #1;
    n_tests++; if ({outstanding_o, busy_o, viol_o, viol_irq_o, viol_cnt_o, first_viol_o, first_vld_o} !== 24'd0) begin
      n_fail++; $display("FAIL rmid_clear got out %0d busy %b viol %b irq %b cnt %0d first %0d/%b exp all 0",
        outstanding_o, busy_o, viol_o, viol_irq_o, viol_cnt_o, first_viol_o, first_vld_o);
    end
    bus_idle(); m_reset();
    #2 async_rst_n_i = 1;
    @(posedge clk_i); #1;
    cyc = 1;
    repeat (12) step();
    n_tests++; if (viol_o !== 7'd0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL rmid_after got viol %b busy %b exp 0 1", viol_o, busy_o); end
    end_cyc();
  endtask

  task automatic test_random();
    logic [23:0] got, exp_v;
    for (int c = 0; c < 600; c++) begin
      cyc   = ($urandom_range(0, 99) >= 4);
      if (!(m_pss && $urandom_range(0, 3) != 0)) begin
        adr = 16'($urandom_range(0, 3) * 4); sel = 2'($urandom); we = 1'($urandom); dat = 16'($urandom_range(0, 3));
      end
      stb   = 1'($urandom);
      stall = ($urandom_range(0, 2) == 0);
      ack   = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      err   = ($urandom_range(0, 24) == 0);
      rty   = ($urandom_range(0, 24) == 0);
      clr_i = ($urandom_range(0, 39) == 0);
      step();
      got   = {outstanding_o, busy_o, viol_o, viol_irq_o, viol_cnt_o, first_viol_o, first_vld_o};
      exp_v = {3'(m_q.size()), (m_state != 0), m_viol, (m_viol != 0), 8'(m_cnt), 3'(m_first), m_fvld};
      n_tests++; if (got !== exp_v) begin n_fail++; $display("FAIL rand[%0d] got %h exp %h", c, got, exp_v); end
    end
    bus_idle(); step();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; m_seq = 0;
    bus_idle(); m_reset();
    async_rst_n_i = 0;
    repeat (2) @(posedge clk_i);
    #1 async_rst_n_i = 1;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_multi_term();
    test_timeout();
    test_stall_unstable();
    test_clr_unexp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
